motor_ramp_sequencer: RTL and testbench
=======================================

// Module: motor_ramp_sequencer
// PURPOSE
//  Sequences the partial-ramp motor start: steps the drive level 30% -> 50% -> 100% and back down on stop.
//  Dwell time per step is counted in prescaler ticks, fast or slow according to the selected mode.
//  Sits between the 1 Hz prescaler tick and the out_30/out_50/out_100 level outputs on uo_out[2:0].
//  Adds a latched fault shutdown that forces all levels off.
// PARAMETERS
//  DWELL_FAST  2  ticks spent in each intermediate step in fast mode (must be >= 1)
//  DWELL_SLOW  5  ticks spent in each intermediate step in slow mode (must be >= 1)
//  CNT_W       4  dwell counter width; must hold max(DWELL_FAST, DWELL_SLOW) - 1
// PORTS
//  clk            in   1  system clock; the only clock
//  reset          in   1  asynchronous, active-high reset
//  tick           in   1  one-cycle enable pulse from the prescaler (1 Hz)
//  start          in   1  level request to start; sampled in IDLE only
//  stop           in   1  level request to stop / ramp down
//  rapido         in   1  fast mode select (ui_in[0])
//  lento          in   1  slow mode select (ui_in[1])
//  fault          in   1  external fault, level-sensitive
//  clr_fault      in   1  clears a latched fault
//  out_30         out  1  30% drive level active
//  out_50         out  1  50% drive level active
//  out_100        out  1  100% drive level active
//  busy           out  1  any state other than IDLE or FAULT
//  at_speed       out  1  state is RUN
//  fault_latched  out  1  state is FAULT
//  state_o        out  3  current state code, for debug
// BEHAVIOUR
//  - States and codes: IDLE=0, UP30=1, UP50=2, RUN=3, DN50=4, DN30=5, FAULT=6. Code 7 is illegal and recovers to IDLE on the next edge.
//  - Reset (async, high): state=IDLE, dwell count=0, mode=fast, all outputs 0.
//  - Outputs are decoded from the state register, so they change on the same edge as the state; at most one level output is 1.
//  - Level by state: UP30 and DN30 -> out_30; UP50 and DN50 -> out_50; RUN -> out_100; IDLE and FAULT -> none.
//  - Mode: sampled only when leaving IDLE; rapido=1,lento=0 -> DWELL_FAST; rapido=0,lento=1 -> DWELL_SLOW.
//    rapido==lento (both 0 or both 1) -> start is ignored and the block stays in IDLE.
//  - The latched dwell value D holds until the block returns to IDLE.
//  - Dwell counting: the counter clears on every state entry. On each tick: if cnt==D-1, advance state and clear; else cnt+1.
//    The block therefore leaves a timed state on the D-th tick after entry.
//  - Timed states are UP30, UP50, DN50 and DN30. IDLE, RUN and FAULT ignore tick.
//  - Transitions, highest priority first:
//    1. fault=1 in any state -> FAULT on the next edge.
//    2. FAULT: clr_fault=1 and fault=0 -> IDLE; otherwise stay in FAULT.
//    3. stop=1: IDLE->IDLE, UP30->IDLE, UP50->DN30, RUN->DN50, DN50/DN30 continue their dwell unchanged.
//       stop wins over start and over tick in the same cycle; the counter clears on the new state entry.
//    4. IDLE with start=1 and a valid mode -> UP30.
//    5. Dwell expiry: UP30->UP50, UP50->RUN, DN50->DN30, DN30->IDLE.
//  - start during UP/DN/RUN is ignored, so there is no restart mid-ramp. DN* states run to IDLE even if start is held.
//  - RUN holds indefinitely until stop or fault.
//  - A tick pulse longer than one cycle counts once per cycle it is high; the prescaler must deliver single-cycle pulses.
//  - Reset mid-ramp returns to IDLE immediately, with outputs forced to 0 asynchronously.
// TESTING
//  1. rapido=1, start pulse, 6 ticks -> UP30 for 2 ticks, UP50 for 2 ticks, then RUN; out_100=1 and at_speed=1 from the 4th tick.
//  2. lento=1, start -> out_30 held for exactly 5 ticks, then out_50 for 5 ticks, then RUN; count the ticks at each edge.
//  3. In RUN with fast mode, assert stop -> DN50 (2 ticks) -> DN30 (2 ticks) -> IDLE; busy=0 after the 4th tick.
//  4. stop in UP30 -> IDLE next cycle; stop in UP50 -> DN30; start+stop together in IDLE -> stays IDLE.
//  5. rapido=lento=1 (and rapido=lento=0), start -> state_o stays 0 and no level output rises.
//  6. fault during UP50 -> FAULT, outputs 0, fault_latched=1.
//     clr_fault while fault=1 -> stays in FAULT; clr_fault after fault drops -> IDLE.
//     Async reset mid-RUN -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/motor_ramp_sequencer.sv
// Partial-ramp motor start sequencer: steps 30% -> 50% -> 100% on start and back down on stop,
// timing each intermediate step in prescaler ticks, with a latched fault shutdown.
module motor_ramp_sequencer #(
   parameter int unsigned DWELL_FAST = 2,
   parameter int unsigned DWELL_SLOW = 5,
   parameter int unsigned CNT_W      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic       stop,
   input  logic       rapido,
   input  logic       lento,
   input  logic       fault,
   input  logic       clr_fault,
   output logic       out_30,
   output logic       out_50,
   output logic       out_100,
   output logic       busy,
   output logic       at_speed,
   output logic       fault_latched,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_UP30    = 3'd1,
      S_UP50    = 3'd2,
      S_RUN     = 3'd3,
      S_DN50    = 3'd4,
      S_DN30    = 3'd5,
      S_FAULT   = 3'd6,
      S_ILLEGAL = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] FAST_MAX = CNT_W'(DWELL_FAST - 1);
   localparam logic [CNT_W-1:0] SLOW_MAX = CNT_W'(DWELL_SLOW - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [CNT_W-1:0] dmax, dmax_next;
   logic             expire;
   logic             out_30_next, out_50_next, out_100_next;
   logic             busy_next, at_speed_next, fault_latched_next;

   assign expire  = tick && (cnt == dmax);
   assign state_o = 3'(state);

   // Next state, dwell counter and latched dwell limit
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      dmax_next  = dmax;
      if (fault) begin
         state_next = S_FAULT;
      end else begin
         case (state)
            S_IDLE: begin
               if (!stop && start && (rapido != lento)) begin
                  state_next = S_UP30;
                  dmax_next  = rapido ? FAST_MAX : SLOW_MAX;
               end
            end
            S_UP30: begin
               if (stop)        state_next = S_IDLE;
               else if (expire) state_next = S_UP50;
               else if (tick)   cnt_next   = cnt + CNT_W'(1);
            end
            S_UP50: begin
               if (stop)        state_next = S_DN30;
               else if (expire) state_next = S_RUN;
               else if (tick)   cnt_next   = cnt + CNT_W'(1);
            end
            S_RUN: begin
               if (stop) state_next = S_DN50;
            end
            S_DN50: begin
               if (expire)    state_next = S_DN30;
               else if (tick) cnt_next   = cnt + CNT_W'(1);
            end
            S_DN30: begin
               if (expire)    state_next = S_IDLE;
               else if (tick) cnt_next   = cnt + CNT_W'(1);
            end
            S_FAULT: begin
               if (clr_fault) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
         endcase
      end
      // Counter restarts on every state entry
      if (state_next != state) cnt_next = '0;
   end

   // Output decode of the next state so outputs flip on the same edge as the state
   always_comb begin
      out_30_next        = (state_next == S_UP30) || (state_next == S_DN30);
      out_50_next        = (state_next == S_UP50) || (state_next == S_DN50);
      out_100_next       = (state_next == S_RUN);
      at_speed_next      = (state_next == S_RUN);
      fault_latched_next = (state_next == S_FAULT);
      busy_next          = (state_next == S_UP30) || (state_next == S_UP50) ||
                           (state_next == S_RUN)  || (state_next == S_DN50) ||
                           (state_next == S_DN30);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         dmax          <= FAST_MAX;
         out_30        <= 1'b0;
         out_50        <= 1'b0;
         out_100       <= 1'b0;
         busy          <= 1'b0;
         at_speed      <= 1'b0;
         fault_latched <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         dmax          <= dmax_next;
         out_30        <= out_30_next;
         out_50        <= out_50_next;
         out_100       <= out_100_next;
         busy          <= busy_next;
         at_speed      <= at_speed_next;
         fault_latched <= fault_latched_next;
      end
   end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer: ramp timing in both modes, stop handling,
// invalid mode rejection, fault latch/clear and asynchronous reset.
module tb_motor_ramp_sequencer;

   logic       clk = 1'b0;
   logic       reset, tick, start, stop, rapido, lento, fault, clr_fault;
   logic       out_30, out_50, out_100, busy, at_speed, fault_latched;
   logic [2:0] state_o;

   int checks   = 0;
   int failures = 0;

   // Observed vector: {out_30,out_50,out_100,busy,at_speed,fault_latched,state_o}
   localparam logic [8:0] V_IDLE  = 9'b000_000_000;
   localparam logic [8:0] V_UP30  = 9'b100_100_001;
   localparam logic [8:0] V_UP50  = 9'b010_100_010;
   localparam logic [8:0] V_RUN   = 9'b001_110_011;
   localparam logic [8:0] V_DN50  = 9'b010_100_100;
   localparam logic [8:0] V_DN30  = 9'b100_100_101;
   localparam logic [8:0] V_FAULT = 9'b000_001_110;

   motor_ramp_sequencer #(.DWELL_FAST(2), .DWELL_SLOW(5), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
      .rapido(rapido), .lento(lento), .fault(fault), .clr_fault(clr_fault),
      .out_30(out_30), .out_50(out_50), .out_100(out_100), .busy(busy),
      .at_speed(at_speed), .fault_latched(fault_latched), .state_o(state_o)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] obs();
      return {out_30, out_50, out_100, busy, at_speed, fault_latched, state_o};
   endfunction

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic tick_once();
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
   endtask

   task automatic start_pulse();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic stop_pulse();
      @(negedge clk) stop = 1'b1;
      @(negedge clk) stop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle();
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL reset_held got=%b exp=%b", obs(), V_IDLE);
      end
      reset = 1'b0;
      tick_once();
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL reset_idle_tick got=%b exp=%b", obs(), V_IDLE);
      end
   endtask

   task automatic test_fast_ramp();
      logic [8:0] exp;
      rapido = 1'b1; lento = 1'b0;
      start_pulse();
      checks++;
      if (obs() !== V_UP30) begin
         failures++; $display("FAIL fast_entry got=%b exp=%b", obs(), V_UP30);
      end
      for (int i = 1; i <= 6; i++) begin
         tick_once();
         exp = (i < 2) ? V_UP30 : (i < 4) ? V_UP50 : V_RUN;
         checks++;
         if (obs() !== exp) begin
            failures++; $display("FAIL fast_tick%0d got=%b exp=%b", i, obs(), exp);
         end
      end
   endtask

   task automatic test_stop_from_run();
      logic [8:0] exp;
      stop_pulse();
      checks++;
      if (obs() !== V_DN50) begin
         failures++; $display("FAIL run_stop got=%b exp=%b", obs(), V_DN50);
      end
      start = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick_once();
         exp = (i < 2) ? V_DN50 : (i < 4) ? V_DN30 : V_IDLE;
         checks++;
         if (obs() !== exp) begin
            failures++; $display("FAIL down_tick%0d got=%b exp=%b", i, obs(), exp);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_slow_ramp();
      logic [8:0] exp;
      rapido = 1'b0; lento = 1'b1;
      start_pulse();
      // Mode flips after leaving IDLE must not alter the latched dwell
      rapido = 1'b1; lento = 1'b0;
      checks++;
      if (obs() !== V_UP30) begin
         failures++; $display("FAIL slow_entry got=%b exp=%b", obs(), V_UP30);
      end
      for (int i = 1; i <= 11; i++) begin
         tick_once();
         exp = (i < 5) ? V_UP30 : (i < 10) ? V_UP50 : V_RUN;
         checks++;
         if (obs() !== exp) begin
            failures++; $display("FAIL slow_tick%0d got=%b exp=%b", i, obs(), exp);
         end
      end
      stop_pulse();
      for (int i = 0; i < 10; i++) tick_once();
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL slow_ramp_down got=%b exp=%b", obs(), V_IDLE);
      end
   endtask

   task automatic test_stop_mid_ramp();
      rapido = 1'b1; lento = 1'b0;
      start_pulse();
      stop_pulse();
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL stop_up30 got=%b exp=%b", obs(), V_IDLE);
      end
      start_pulse();
      tick_once();
      tick_once();
      checks++;
      if (obs() !== V_UP50) begin
         failures++; $display("FAIL reach_up50 got=%b exp=%b", obs(), V_UP50);
      end
      // stop and tick together: stop wins, counter restarts in DN30
      @(negedge clk) begin stop = 1'b1; tick = 1'b1; end
      @(negedge clk) begin stop = 1'b0; tick = 1'b0; end
      checks++;
      if (obs() !== V_DN30) begin
         failures++; $display("FAIL stop_up50 got=%b exp=%b", obs(), V_DN30);
      end
      tick_once();
      checks++;
      if (obs() !== V_DN30) begin
         failures++; $display("FAIL dn30_hold got=%b exp=%b", obs(), V_DN30);
      end
      tick_once();
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL dn30_exit got=%b exp=%b", obs(), V_IDLE);
      end
      @(negedge clk) begin start = 1'b1; stop = 1'b1; end
      cycle();
      cycle();
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL start_stop_idle got=%b exp=%b", obs(), V_IDLE);
      end
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic test_invalid_mode();
      for (int m = 0; m < 2; m++) begin
         rapido = m[0]; lento = m[0];
         @(negedge clk) start = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk) tick = ~tick;
            checks++;
            if (obs() !== V_IDLE) begin
               failures++; $display("FAIL bad_mode%0d_c%0d got=%b exp=%b", m, c, obs(), V_IDLE);
            end
         end
         start = 1'b0; tick = 1'b0;
      end
   endtask

   task automatic test_fault();
      rapido = 1'b1; lento = 1'b0;
      start_pulse();
      tick_once();
      tick_once();
      @(negedge clk) fault = 1'b1;
      cycle();
      checks++;
      if (obs() !== V_FAULT) begin
         failures++; $display("FAIL fault_entry got=%b exp=%b", obs(), V_FAULT);
      end
      clr_fault = 1'b1;
      cycle();
      checks++;
      if (obs() !== V_FAULT) begin
         failures++; $display("FAIL clr_while_fault got=%b exp=%b", obs(), V_FAULT);
      end
      clr_fault = 1'b0; fault = 1'b0; start = 1'b1;
      cycle();
      cycle();
      checks++;
      if (obs() !== V_FAULT) begin
         failures++; $display("FAIL fault_sticky got=%b exp=%b", obs(), V_FAULT);
      end
      start = 1'b0; clr_fault = 1'b1;
      cycle();
      clr_fault = 1'b0;
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL fault_clear got=%b exp=%b", obs(), V_IDLE);
      end
   endtask

   task automatic test_async_reset();
      start_pulse();
      for (int i = 0; i < 4; i++) tick_once();
      checks++;
      if (obs() !== V_RUN) begin
         failures++; $display("FAIL pre_reset_run got=%b exp=%b", obs(), V_RUN);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL async_reset got=%b exp=%b", obs(), V_IDLE);
      end
      @(negedge clk) reset = 1'b0;
      tick_once();
      checks++;
      if (obs() !== V_IDLE) begin
         failures++; $display("FAIL post_reset got=%b exp=%b", obs(), V_IDLE);
      end
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
      rapido = 1'b0; lento = 1'b0; fault = 1'b0; clr_fault = 1'b0;
      test_reset();
      test_fast_ramp();
      test_stop_from_run();
      test_slow_ramp();
      test_stop_mid_ramp();
      test_invalid_mode();
      test_fault();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
